// File: rtl/ps_rr_packet_arbiter_pkg.sv
// Shared types and helpers for the PacketStream round-robin arbiters.
// rr_pick is the generic round-robin search used by software-style models and wider arbiters.
package ps_arb_pkg;

    typedef enum logic {ST_IDLE, ST_BUSY} ps_arb_state_t;

    localparam int MAX_INPUTS = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // Returns the first requesting index at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [MAX_INPUTS-1:0] req,
                                         input int unsigned n,
                                         input int unsigned ptr);
        rr_pick_t    res;
        int unsigned idx_k;
        res = '0;
        for (int k = int'(n) - 1; k >= 0; k--) begin
            idx_k = (ptr + unsigned'(k)) % n;
            if (req[idx_k]) begin
                res.found = 1'b1;
                res.idx   = 5'(idx_k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ps_rr_packet_arbiter_picker.sv
// Combinational round-robin index picker: rotate by ptr, priority-encode, unrotate.
module rr_index_picker #(
    parameter  int INPUTS = 4,
    localparam int IDX_W  = $clog2(INPUTS)
) (
    input  logic [INPUTS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    logic [2*INPUTS-1:0] req_dbl;
    logic [INPUTS-1:0]   rot;
    logic [IDX_W-1:0]    off;
    logic [IDX_W:0]      sum;

    always_comb begin
        req_dbl = {req, req} >> ptr;
        rot     = req_dbl[INPUTS-1:0];
        off     = '0;
        // Descending scan so the lowest rotated position (closest to ptr) wins.
        for (int i = INPUTS - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDX_W+1)'(INPUTS)) sum = sum - (IDX_W+1)'(INPUTS);
        idx   = sum[IDX_W-1:0];
        found = |req;
    end

endmodule

// File: rtl/ps_rr_packet_arbiter.sv
// Packet-granular round-robin arbiter: one PacketStream sink shared by INPUTS sources.
// A granted source keeps the sink until its eop word is transferred.
module ps_rr_packet_arbiter
    import ps_arb_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int INPUTS = 4,
    localparam int IDX_W  = $clog2(INPUTS)
) (
    input  logic                          reset,
    input  logic                          clk,
    input  logic [INPUTS-1:0][WIDTH-1:0]  i_dat,
    input  logic [INPUTS-1:0]             i_val,
    input  logic [INPUTS-1:0]             i_eop,
    output logic [INPUTS-1:0]             i_rdy,
    output logic [WIDTH-1:0]              o_dat,
    output logic                          o_val,
    output logic                          o_eop,
    input  logic                          o_rdy,
    output logic [IDX_W-1:0]              o_sel
);

    ps_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] cand;
    logic             cand_found;
    logic [IDX_W-1:0] cur;
    logic             active;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(INPUTS - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_index_picker #(.INPUTS(INPUTS)) u_picker (
        .req   (i_val),
        .ptr   (ptr_q),
        .idx   (cand),
        .found (cand_found)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cur     = ptr_q;
        active  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cand_found) begin
                    cur    = cand;
                    active = 1'b1;
                    // A stalled or multi-word offer locks the candidate so it is never withdrawn.
                    if (i_val[cand] && o_rdy && i_eop[cand]) begin
                        ptr_d = next_idx(cand);
                    end else begin
                        sel_d   = cand;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cur    = sel_q;
                active = 1'b1;
                if (i_val[sel_q] && o_rdy && i_eop[sel_q]) begin
                    ptr_d   = next_idx(sel_q);
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Outputs are forced quiet while reset is held, even with sources valid.
        active     = active & reset;
        o_sel      = cur;
        o_dat      = i_dat[cur];
        o_val      = active & i_val[cur];
        o_eop      = o_val & i_eop[cur];
        i_rdy      = '0;
        i_rdy[cur] = active & o_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_ps_rr_packet_arbiter.sv
// Self-checking bench for ps_rr_packet_arbiter (INPUTS=4, WIDTH=8): directed scenarios
// plus randomized traffic against a packet-level round-robin reference model.
module tb_ps_rr_packet_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0][7:0] i_dat;
    logic [N-1:0]    i_val;
    logic [N-1:0]    i_eop;
    logic [N-1:0]    i_rdy;
    logic [7:0]      o_dat;
    logic            o_val;
    logic            o_eop;
    logic            o_rdy;
    logic [1:0]      o_sel;

    int checks = 0;
    int errors = 0;

    // Reference model: the owner holds the sink until its eop passes; otherwise the
    // first valid source scanning from ptr gets it.
    int         m_ptr   = 0;
    int         m_owner = -1;
    int         e_cand;
    logic       e_has;
    logic       e_val;
    logic       e_eop;
    logic [7:0] e_dat;
    logic [1:0] e_sel;
    logic [3:0] e_rdy;

    ps_rr_packet_arbiter #(.WIDTH(8), .INPUTS(N)) dut (
        .reset (reset),
        .clk   (clk),
        .i_dat (i_dat),
        .i_val (i_val),
        .i_eop (i_eop),
        .i_rdy (i_rdy),
        .o_dat (o_dat),
        .o_val (o_val),
        .o_eop (o_eop),
        .o_rdy (o_rdy),
        .o_sel (o_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_eval();
        e_has  = 1'b0;
        e_cand = 0;
        if (reset) begin
            if (m_owner >= 0) begin
                e_has  = 1'b1;
                e_cand = m_owner;
            end else begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (i_val[(m_ptr + k) % N]) begin
                        e_has  = 1'b1;
                        e_cand = (m_ptr + k) % N;
                    end
                end
            end
        end
        e_sel = e_has ? 2'(e_cand) : 2'(m_ptr);
        e_val = e_has && i_val[e_cand];
        e_eop = e_val && i_eop[e_cand];
        e_dat = i_dat[e_cand];
        e_rdy = (e_has && o_rdy) ? 4'(1 << e_cand) : 4'b0000;
    endtask

    task automatic model_advance();
        if (!reset) begin
            m_ptr   = 0;
            m_owner = -1;
        end else if (e_has) begin
            if (o_rdy && i_val[e_cand] && i_eop[e_cand]) begin
                m_owner = -1;
                m_ptr   = (e_cand + 1) % N;
            end else begin
                m_owner = e_cand;
            end
        end
    endtask

    task automatic tick();
        model_eval();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_val = '0;
        i_eop = '0;
        i_dat = '0;
        o_rdy = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_val = 4'hF;
        i_eop = 4'hF;
        o_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_val !== 1'b0 || i_rdy !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_quiet: o_val=%b i_rdy=%b required o_val=0 i_rdy=0000", o_val, i_rdy);
            end
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_sel !== 2'd0 || i_rdy !== 4'b0001 || o_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release: o_sel=%0d i_rdy=%b o_val=%b required 0 0001 1", o_sel, i_rdy, o_val);
        end
        tick();
    endtask

    task automatic test_packet_hold();
        logic [7:0] a [3];
        logic [7:0] b [2];
        logic [7:0] exp_dat [5];
        logic [3:0] exp_rdy [5];
        do_reset();
        for (int k = 0; k < 3; k++) a[k] = 8'($urandom);
        for (int k = 0; k < 2; k++) b[k] = 8'($urandom);
        exp_dat = '{a[0], a[1], a[2], b[0], b[1]};
        exp_rdy = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        o_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            i_val    = {1'b0, c < 5, c < 3, 1'b0};
            i_eop[1] = (c == 2);
            i_dat[1] = a[c < 3 ? c : 2];
            i_eop[2] = (c == 4);
            i_dat[2] = b[c < 3 ? 0 : c - 3];
            @(negedge clk);
            checks++;
            if (o_dat !== exp_dat[c] || o_val !== 1'b1) begin
                errors++;
                $display("[TB] FAIL pkt_hold_dat c%0d: o_dat=%h o_val=%b required %h 1", c, o_dat, o_val, exp_dat[c]);
            end
            checks++;
            if (i_rdy !== exp_rdy[c]) begin
                errors++;
                $display("[TB] FAIL pkt_hold_rdy c%0d: i_rdy=%b required %b", c, i_rdy, exp_rdy[c]);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        int cnt [N];
        do_reset();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        i_val = 4'hF;
        i_eop = 4'hF;
        o_rdy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) i_dat[k] = 8'($urandom);
            @(negedge clk);
            checks++;
            if (o_sel !== 2'(c % N)) begin
                errors++;
                $display("[TB] FAIL rotation_sel c%0d: o_sel=%0d required %0d", c, o_sel, c % N);
            end
            for (int k = 0; k < N; k++) if (i_rdy[k] && i_val[k]) cnt[k]++;
            tick();
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (cnt[k] != 100) begin
                errors++;
                $display("[TB] FAIL rotation_share ch%0d: transfers=%0d required 100", k, cnt[k]);
            end
        end
    endtask

    task automatic test_stall_lock();
        logic [7:0] d;
        do_reset();
        d        = 8'($urandom);
        i_val    = 4'b1000;
        i_eop    = 4'b1000;
        i_dat[3] = d;
        i_dat[0] = ~d;
        o_rdy    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) i_val[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (o_sel !== 2'd3 || o_val !== 1'b1 || o_dat !== d || i_rdy !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL stall_lock c%0d: sel=%0d val=%b dat=%h rdy=%b required 3 1 %h 0000", c, o_sel, o_val, o_dat, i_rdy, d);
            end
            tick();
        end
        o_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (o_sel !== 2'd3 || i_rdy !== 4'b1000 || o_eop !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_grant: sel=%0d rdy=%b eop=%b required 3 1000 1", o_sel, i_rdy, o_eop);
        end
        tick();
        i_val[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (o_sel !== 2'd0 || i_rdy !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL stall_next: sel=%0d rdy=%b required 0 0001", o_sel, i_rdy);
        end
        tick();
    endtask

    task automatic test_gap();
        do_reset();
        o_rdy = 1'b1;
        i_val = 4'b0100;
        i_eop = 4'b0000;
        tick();
        i_val = 4'b0001;
        i_eop = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (o_val !== 1'b0 || o_sel !== 2'd2 || i_rdy[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL gap_hold c%0d: val=%b sel=%0d rdy0=%b required 0 2 0", c, o_val, o_sel, i_rdy[0]);
            end
            tick();
        end
        i_val = 4'b0101;
        i_eop = 4'b0101;
        @(negedge clk);
        checks++;
        if (o_sel !== 2'd2 || i_rdy !== 4'b0100 || o_eop !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gap_eop: sel=%0d rdy=%b eop=%b required 2 0100 1", o_sel, i_rdy, o_eop);
        end
        tick();
        i_val = 4'b0001;
        @(negedge clk);
        checks++;
        if (o_sel !== 2'd0 || i_rdy !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL gap_next: sel=%0d rdy=%b required 0 0001", o_sel, i_rdy);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        o_rdy = 1'b1;
        i_val = 4'b0010;
        i_eop = 4'b0000;
        tick();
        i_val = 4'b0011;
        #2;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (o_val !== 1'b0 || i_rdy !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midpkt_reset: val=%b rdy=%b required 0 0000", o_val, i_rdy);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_sel !== 2'd0 || i_rdy !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL midpkt_release: sel=%0d rdy=%b required 0 0001", o_sel, i_rdy);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                i_val[k] = ($urandom_range(0, 3) != 0);
                i_eop[k] = ($urandom_range(0, 2) == 0);
                i_dat[k] = 8'($urandom);
            end
            o_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_eval();
            checks++;
            if (o_val !== e_val || o_sel !== e_sel || i_rdy !== e_rdy) begin
                errors++;
                $display("[TB] FAIL rand_ctrl c%0d: val=%b sel=%0d rdy=%b required %b %0d %b", c, o_val, o_sel, i_rdy, e_val, e_sel, e_rdy);
            end
            if (e_val) begin
                checks++;
                if (o_dat !== e_dat || o_eop !== e_eop) begin
                    errors++;
                    $display("[TB] FAIL rand_data c%0d: dat=%h eop=%b required %h %b", c, o_dat, o_eop, e_dat, e_eop);
                end
            end
            checks++;
            if ($countones(i_rdy) > 1) begin
                errors++;
                $display("[TB] FAIL rand_onehot c%0d: i_rdy=%b required at most one bit", c, i_rdy);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        i_val = '0;
        i_eop = '0;
        i_dat = '0;
        o_rdy = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_packet_hold();
        test_rotation();
        test_stall_lock();
        test_gap();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
